// File: rtl/mem_arbiter_rr.sv
// N-port cache-line memory arbiter: one transaction at a time onto a cs/handshaked/rvalid port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index).

module mem_arb_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sel_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  grant_i,
  input  logic                  resp_fire_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o,
  output logic                  rvalid_o
);
  logic rvalid_q;

  // Masked contributions; the top ORs all ports together as a one-hot mux.
  assign addr_o  = sel_i ? addr_i  : '0;
  assign wdata_o = sel_i ? wdata_i : '0;
  assign we_o    = sel_i & we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rvalid_q <= 1'b0;
    else         rvalid_q <= resp_fire_i & grant_i;
  end

  assign rvalid_o = rvalid_q;
endmodule

module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_cs_i,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  output logic [DATA_WIDTH-1:0]           req_rdata_o,
  output logic [NUM_PORTS-1:0]            req_rvalid_o,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           wdata_o,
  output logic                            we_o,
  output logic                            cs_o,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  input  logic                            rvalid_i,
  input  logic                            handshaked_i,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic                            busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    we_q, we_d;
  logic                    cs_q, cs_d;
  logic                    busy_q, busy_d;
  logic                    resp_fire;

  logic [NUM_PORTS-1:0]                 win_oh;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata;
  logic [NUM_PORTS-1:0]                 port_we;
  logic [NUM_PORTS-1:0]                 port_rvalid;
  logic [ADDR_WIDTH-1:0]                win_addr;
  logic [DATA_WIDTH-1:0]                win_wdata;
  logic                                 win_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int PW = $clog2(NUM_PORTS);
  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts just above the last winner, so that port becomes lowest priority.
  always_comb begin
    int   idx;
    logic found;
    win_oh = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && req_cs_i[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (win_oh[k]) ptr_d = PW'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= PW'(NUM_PORTS - 1);
    else         ptr_q <= ptr_d;
  end
`else
  // Isolate the lowest set request bit.
  assign win_oh = req_cs_i & (~req_cs_i + NUM_PORTS'(1));
`endif

  assign resp_fire = (state_d == RESP);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    mem_arb_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sel_i       (win_oh[k]),
      .addr_i      (req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata_i     (req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .we_i        (req_we_i[k]),
      .grant_i     (grant_q[k]),
      .resp_fire_i (resp_fire),
      .addr_o      (port_addr[k]),
      .wdata_o     (port_wdata[k]),
      .we_o        (port_we[k]),
      .rvalid_o    (port_rvalid[k])
    );
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      win_addr  = win_addr  | port_addr[k];
      win_wdata = win_wdata | port_wdata[k];
    end
  end

  assign win_we = |port_we;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cs_d    = cs_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req_cs_i) begin
          state_d = REQ;
          grant_d = win_oh;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          we_d    = win_we;
          cs_d    = 1'b1;
        end
      end
      REQ: begin
        if (handshaked_i) begin
          cs_d = 1'b0;
          if (rvalid_i) begin
            rdata_d = rdata_i;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cs_q    <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cs_q    <= cs_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_rdata_o  = rdata_q;
  assign req_rvalid_o = port_rvalid;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;
  assign we_o         = we_q;
  assign cs_o         = cs_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (4 ports): transaction-level model checked every cycle plus directed literals.
module tb_mem_arbiter_rr;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_cs = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   req_rdata_o;
  logic [N-1:0]    req_rvalid_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   wdata_o;
  logic            we_o, cs_o, busy_o;
  logic [DW-1:0]   rdata = '0;
  logic            rvalid = 1'b0, hs = 1'b0;
  logic [N-1:0]    grant_o;

  int compared = 0;
  int mismatched = 0;

  localparam logic [DW-1:0] DEADBEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [DW-1:0] W0 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_cs_i(req_cs), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rdata_o(req_rdata_o),
    .req_rvalid_o(req_rvalid_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
    .cs_o(cs_o), .rdata_i(rdata), .rvalid_i(rvalid), .handshaked_i(hs),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k] && last >= -1) return k;
`endif
    return -1;
  endfunction

  // Model: phase 0 idle, 1 issued, 2 accepted, 3 completed; owner -1 when none.
  int            m_ph, m_own, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_we;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ph <= 0; m_own <= -1; m_last <= N - 1;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_we <= 1'b0;
    end else if (m_ph == 0) begin
      if (req_cs != 0) begin
        m_own   <= pick(req_cs, m_last);
        m_last  <= pick(req_cs, m_last);
        m_addr  <= req_addr[pick(req_cs, m_last)*AW +: AW];
        m_wdata <= req_wdata[pick(req_cs, m_last)*DW +: DW];
        m_we    <= req_we[pick(req_cs, m_last)];
        m_ph    <= 1;
      end
    end else if (m_ph == 1) begin
      if (hs) begin
        m_ph <= rvalid ? 3 : 2;
        if (rvalid) m_rdata <= rdata;
      end
    end else if (m_ph == 2) begin
      if (rvalid) begin m_ph <= 3; m_rdata <= rdata; end
    end else begin
      m_ph <= 0; m_own <= -1;
    end
  end

  logic [N-1:0] e_grant;
  always @(negedge clk) begin
    e_grant = '0;
    if (m_own >= 0) e_grant[m_own] = 1'b1;
    chk("m_cs",     DW'(cs_o),         DW'(m_ph == 1));
    chk("m_busy",   DW'(busy_o),       DW'(m_ph != 0));
    chk("m_grant",  DW'(grant_o),      DW'(e_grant));
    chk("m_rvalid", DW'(req_rvalid_o), (m_ph == 3) ? DW'(e_grant) : '0);
    chk("m_addr",   DW'(addr_o),       DW'(m_addr));
    chk("m_wdata",  wdata_o,           m_wdata);
    chk("m_we",     DW'(we_o),         DW'(m_we));
    chk("m_rdata",  req_rdata_o,       m_rdata);
  end

  task automatic cyc();
    @(negedge clk); #2;
  endtask

  int pulses, cs_seen, got, gi;
  int order[5];
  int exp_order[5];

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    cyc(); cyc();
    chk("rst_cs", DW'(cs_o), '0);
    chk("rst_grant", DW'(grant_o), '0);
    chk("rst_busy", DW'(busy_o), '0);
    chk("rst_rdata", req_rdata_o, '0);
    rst_ni = 1'b1;
    cyc();

    // Single read on port 1, handshake in cycle 1, rvalid in cycle 3.
    req_cs = 4'b0010; req_addr[1*AW +: AW] = 32'h0000_1000;
    cyc();
    chk("rd_cs", DW'(cs_o), DW'(1));
    chk("rd_addr", DW'(addr_o), DW'(32'h0000_1000));
    chk("rd_grant", DW'(grant_o), DW'(4'b0010));
    hs = 1'b1; cyc();
    chk("rd_wait_cs", DW'(cs_o), '0);
    hs = 1'b0; cyc();
    rvalid = 1'b1; rdata = DEADBEEF; cyc();
    chk("rd_rvalid", DW'(req_rvalid_o), DW'(4'b0010));
    chk("rd_rdata", req_rdata_o, DEADBEEF);
    rvalid = 1'b0; req_cs = '0; cyc();
    chk("rd_idle_busy", DW'(busy_o), '0);
    chk("rd_rvalid_off", DW'(req_rvalid_o), '0);

    // Single write on port 0, handshake and rvalid together.
    req_cs = 4'b0001; req_we = 4'b0001; req_addr[0 +: AW] = 32'h0000_2000; req_wdata[0 +: DW] = W0;
    cyc();
    chk("wr_we", DW'(we_o), DW'(1));
    chk("wr_wdata", wdata_o, W0);
    chk("wr_addr", DW'(addr_o), DW'(32'h0000_2000));
    hs = 1'b1; rvalid = 1'b1; rdata = 128'h1111; cyc();
    chk("wr_rvalid", DW'(req_rvalid_o), DW'(4'b0001));
    hs = 1'b0; rvalid = 1'b0; req_cs = '0; req_we = '0; cyc();
    chk("wr_idle", DW'(busy_o), '0);

    // Requester drops cs while waiting for the response.
    req_cs = 4'b0100; req_addr[2*AW +: AW] = 32'h0000_3000;
    cyc();
    hs = 1'b1; cyc();
    hs = 1'b0; req_cs = '0; cyc(); cyc();
    rvalid = 1'b1; rdata = 128'h2222; cyc();
    chk("drop_rvalid", DW'(req_rvalid_o), DW'(4'b0100));
    rvalid = 1'b0;
    pulses = 0; cs_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (req_rvalid_o != 0) pulses++;
      if (cs_o) cs_seen++;
    end
    chk("drop_extra_pulses", DW'(pulses), '0);
    chk("drop_reissue", DW'(cs_seen), '0);

    // Reset while waiting; late rvalid must be ignored.
    req_cs = 4'b1000; req_addr[3*AW +: AW] = 32'h0000_4000;
    cyc();
    hs = 1'b1; cyc();
    hs = 1'b0; rst_ni = 1'b0; req_cs = '0; #1;
    chk("arst_busy", DW'(busy_o), '0);
    chk("arst_addr", DW'(addr_o), '0);
    chk("arst_grant", DW'(grant_o), '0);
    chk("arst_rdata", req_rdata_o, '0);
    cyc();
    rst_ni = 1'b1; rvalid = 1'b1; rdata = 128'h3333; cyc();
    chk("arst_no_rvalid", DW'(req_rvalid_o), '0);
    chk("arst_rdata_hold", req_rdata_o, '0);
    rvalid = 1'b0;
    req_cs = 4'b1001; req_addr[0 +: AW] = 32'h0000_5000; cyc();
    chk("arst_first_grant", DW'(grant_o), DW'(4'b0001));
    hs = 1'b1; rvalid = 1'b1; rdata = 128'h4444; cyc();
    chk("arst_rvalid", DW'(req_rvalid_o), DW'(4'b0001));
    hs = 1'b0; rvalid = 1'b0; req_cs = '0; cyc();

    // Handshake withheld for 10 cycles; request fields change meanwhile.
    req_cs = 4'b0010; req_addr[1*AW +: AW] = 32'h0000_6000; cyc();
    req_addr[1*AW +: AW] = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      chk("hs_cs_held", DW'(cs_o), DW'(1));
      chk("hs_addr_stable", DW'(addr_o), DW'(32'h0000_6000));
      cyc();
    end
    hs = 1'b1; rvalid = 1'b1; rdata = 128'h5555; cyc();
    chk("hs_rvalid", DW'(req_rvalid_o), DW'(4'b0010));
    hs = 1'b0; rvalid = 1'b0; req_cs = '0; cyc();

    // Contention from a fresh reset: all four ports request continuously.
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;
    req_cs = 4'b1111; got = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      cyc();
      if (cs_o && !hs) begin
        gi = -1;
        for (int k = 0; k < N; k++) if (grant_o[k]) gi = k;
        order[got] = gi; got++;
        hs = 1'b1; rvalid = 1'b1;
      end else begin
        hs = 1'b0; rvalid = 1'b0;
      end
    end
    chk("cont_count", DW'(got), DW'(5));
    for (int k = 0; k < 5; k++) if (k < got) chk($sformatf("cont_order%0d", k), DW'(order[k]), DW'(exp_order[k]));
    req_cs = '0; hs = 1'b0; rvalid = 1'b0;
    cyc(); cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
